// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM custom instruction: one shared period counter, per-channel duty,
// enable and polarity, with duty/period double-buffered and transferred at the period wrap.
module pwm_multi_channel #(
    parameter logic [7:0]           customId       = 8'h00,
    parameter int unsigned          NR_CHANNELS    = 4,
    parameter int unsigned          CNT_WIDTH      = 20,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = 20'd1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             ciN,
    input  logic [31:0]            valueA,
    input  logic [31:0]            valueB,
    output logic                   done,
    output logic [31:0]            result,
    output logic [NR_CHANNELS-1:0] pwmPins,
    output logic                   periodTick
);

    localparam logic [3:0] OpEnable   = 4'd0;
    localparam logic [3:0] OpDuty     = 4'd1;
    localparam logic [3:0] OpPeriod   = 4'd2;
    localparam logic [3:0] OpReadDuty = 4'd3;
    localparam logic [3:0] OpStatus   = 4'd4;
    localparam logic [3:0] OpPolarity = 4'd5;

    logic [CNT_WIDTH-1:0]   counter_q, counter_d;
    logic [CNT_WIDTH-1:0]   period_active_q, period_shadow_q;
    logic [CNT_WIDTH-1:0]   duty_active_q [NR_CHANNELS];
    logic [CNT_WIDTH-1:0]   duty_shadow_q [NR_CHANNELS];
    logic [NR_CHANNELS-1:0] enable_q, polarity_q;
    logic [NR_CHANNELS-1:0] pins_q, pins_d;
    logic                   tick_q;
    logic                   done_q;
    logic [31:0]            result_q, result_d;

    logic                   accept;
    logic [3:0]             opcode;
    logic [3:0]             ch;
    logic                   wrap;
    logic [CNT_WIDTH-1:0]   duty_rd;
    logic [15:0]            cnt_lo;
    logic [15:0]            en_ext;
    logic [CNT_WIDTH-1:0]   operand;
    logic                   unused_cmd_bits;

    assign accept  = start && (ciN == customId);
    assign opcode  = valueA[3:0];
    assign ch      = valueA[11:8];
    assign operand = valueB[CNT_WIDTH-1:0];
    assign unused_cmd_bits = ^{valueA[31:12], valueA[7:4], valueB};

    // Periods of 0 or 1 degenerate to a counter pinned at 0 that wraps every cycle.
    assign wrap      = (period_active_q <= CNT_WIDTH'(1)) ||
                       (counter_q == period_active_q - CNT_WIDTH'(1));
    assign counter_d = wrap ? '0 : counter_q + CNT_WIDTH'(1);

    always_comb begin
        for (int i = 0; i < int'(NR_CHANNELS); i++) begin
            pins_d[i] = (enable_q[i] & (counter_q < duty_active_q[i])) ^ polarity_q[i];
        end
    end

    // Out-of-range channel indices match no entry and read back as zero.
    always_comb begin
        duty_rd = '0;
        for (int i = 0; i < int'(NR_CHANNELS); i++) begin
            if (ch == 4'(i)) begin
                duty_rd = duty_active_q[i];
            end
        end
    end

    assign cnt_lo = 16'(counter_q);
    assign en_ext = 16'(enable_q);

    always_comb begin
        result_d = '0;
        case (opcode)
            OpReadDuty: result_d = 32'(duty_rd);
            OpStatus:   result_d = {cnt_lo, en_ext};
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q       <= '0;
            period_active_q <= DEFAULT_PERIOD;
            period_shadow_q <= DEFAULT_PERIOD;
            for (int i = 0; i < int'(NR_CHANNELS); i++) begin
                duty_active_q[i] <= '0;
                duty_shadow_q[i] <= '0;
            end
            enable_q   <= '0;
            polarity_q <= '0;
            pins_q     <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            counter_q <= counter_d;
            tick_q    <= wrap;
            pins_q    <= pins_d;
            done_q    <= accept;
            result_q  <= accept ? result_d : '0;

            // Transfer uses the pre-edge shadow, so a same-cycle shadow write waits a period.
            if (wrap) begin
                period_active_q <= period_shadow_q;
                for (int i = 0; i < int'(NR_CHANNELS); i++) begin
                    duty_active_q[i] <= duty_shadow_q[i];
                end
            end

            if (accept) begin
                case (opcode)
                    OpEnable:   enable_q        <= valueB[NR_CHANNELS-1:0];
                    OpPeriod:   period_shadow_q <= operand;
                    OpPolarity: polarity_q      <= valueB[NR_CHANNELS-1:0];
                    default:    ;
                endcase
            end

            for (int i = 0; i < int'(NR_CHANNELS); i++) begin
                if (accept && (opcode == OpDuty) && (ch == 4'(i))) begin
                    duty_shadow_q[i] <= operand;
                end
            end
        end
    end

    assign done       = done_q;
    assign result     = result_q;
    assign pwmPins    = pins_q;
    assign periodTick = tick_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: behavioural model, result scoreboard,
// directed period/duty measurements and a randomized command phase.
module tb_pwm_multi_channel;

    localparam int unsigned NCH = 4;
    localparam int unsigned DEF = 40;
    localparam int unsigned MASK = 32'h000F_FFFF;

    logic           clock;
    logic           reset;
    logic           start;
    logic [7:0]     ciN;
    logic [31:0]    valueA;
    logic [31:0]    valueB;
    logic           done;
    logic [31:0]    result;
    logic [NCH-1:0] pwmPins;
    logic           periodTick;

    pwm_multi_channel #(
        .customId      (8'h00),
        .NR_CHANNELS   (NCH),
        .CNT_WIDTH     (20),
        .DEFAULT_PERIOD(20'd40)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ciN       (ciN),
        .valueA    (valueA),
        .valueB    (valueB),
        .done      (done),
        .result    (result),
        .pwmPins   (pwmPins),
        .periodTick(periodTick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: phase counter modulo the active period.
    typedef struct {
        int unsigned due;
        logic [31:0] res;
    } exp_t;
    exp_t exp_q[$];

    int unsigned cyc = 0;
    bit          model_valid = 0;
    int unsigned m_cnt, m_per_act, m_per_sh, m_nxt;
    int unsigned m_duty_act [NCH];
    int unsigned m_duty_sh [NCH];
    logic [NCH-1:0] m_en, m_pol, m_pins;
    logic        m_tick;
    bit          m_acc;
    int unsigned m_op, m_ch;
    logic [31:0] m_res;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            model_valid = 1;
            m_cnt = 0;
            m_per_act = DEF;
            m_per_sh = DEF;
            for (int i = 0; i < NCH; i++) begin
                m_duty_act[i] = 0;
                m_duty_sh[i] = 0;
            end
            m_en = '0;
            m_pol = '0;
            m_pins = '0;
            m_tick = 1'b0;
        end else if (model_valid) begin
            m_acc = start && (ciN == 8'h00);
            m_op = 32'(valueA[3:0]);
            m_ch = 32'(valueA[11:8]);
            if (m_acc) begin
                m_res = 0;
                if (m_op == 3 && m_ch < NCH) m_res = m_duty_act[m_ch];
                if (m_op == 4) m_res = {m_cnt[15:0], 12'd0, m_en};
                exp_q.push_back('{due: cyc, res: m_res});
            end
            for (int i = 0; i < NCH; i++) begin
                m_pins[i] = (m_en[i] && (m_cnt < m_duty_act[i])) ^ m_pol[i];
            end
            m_nxt = (m_per_act <= 1) ? 0 : (m_cnt + 1) % m_per_act;
            m_tick = (m_nxt == 0);
            if (m_tick) begin
                m_per_act = m_per_sh;
                for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
            end
            m_cnt = m_nxt;
            if (m_acc) begin
                if (m_op == 0) m_en = valueB[NCH-1:0];
                if (m_op == 5) m_pol = valueB[NCH-1:0];
                if (m_op == 2) m_per_sh = valueB & MASK;
                if (m_op == 1 && m_ch < NCH) m_duty_sh[m_ch] = valueB & MASK;
            end
        end
    end

    // Monitor: checks every cycle away from the active edge.
    always @(negedge clock) begin
        if (model_valid) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("done", 32'(done), 32'd1);
                check("result", result, exp_q[0].res);
                void'(exp_q.pop_front());
            end else begin
                check("done_idle", 32'(done), 32'd0);
                check("result_idle", result, 32'd0);
            end
            check("pwmPins", 32'(pwmPins), 32'(m_pins));
            check("periodTick", 32'(periodTick), 32'(m_tick));
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cmd(input int unsigned op, input int unsigned ch, input logic [31:0] b,
                       input logic [7:0] ci = 8'h00);
        start = 1'b1;
        ciN = ci;
        valueA = {20'd0, 4'(ch), 4'd0, 4'(op)};
        valueB = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        ciN = 8'h00;
        valueA = '0;
        valueB = '0;
    endtask

    // Skip nticks wraps, then count high samples and ticks over len cycles.
    task automatic measure(input string name, input int unsigned chn, input int unsigned nticks,
                           input int unsigned len, input int unsigned exp_high);
        int unsigned seen, hi, ticks;
        seen = 0;
        hi = 0;
        ticks = 0;
        for (int k = 0; k < 200 && seen < nticks; k++) begin
            @(negedge clock);
            if (periodTick) seen++;
        end
        check({name, "_sync"}, seen, nticks);
        for (int k = 0; k < int'(len); k++) begin
            @(negedge clock);
            if (pwmPins[chn]) hi++;
            if (periodTick) ticks++;
        end
        check({name, "_high"}, hi, exp_high);
        check({name, "_ticks"}, ticks, 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int unsigned op, ch, gap, len;
        logic [31:0] b;
        bit seen;
        reset = 1'b1;
        start = 1'b0;
        ciN = 8'h00;
        valueA = '0;
        valueB = '0;
        idle(3);
        reset = 1'b0;

        cmd(4, 0, 0);
        cmd(3, 0, 0);

        cmd(2, 0, 10);
        cmd(1, 0, 3);
        cmd(0, 0, 1);
        measure("p10_d3", 0, 2, 10, 3);

        cmd(1, 0, 8);
        cmd(3, 0, 0);
        measure("d8", 0, 1, 10, 8);
        cmd(3, 0, 0);

        cmd(1, 1, 0);
        cmd(0, 0, 3);
        measure("ch1_d0", 1, 2, 10, 0);
        cmd(1, 1, 12);
        measure("ch1_d12", 1, 2, 10, 10);
        cmd(5, 0, 2);
        measure("ch1_inv", 1, 2, 10, 0);
        cmd(0, 0, 1);
        measure("ch1_dis", 1, 2, 10, 10);
        cmd(5, 0, 0);

        for (int k = 0; k < 50 && m_cnt != 9; k++) idle(1);
        cmd(1, 0, 6);
        measure("wrap_old", 0, 1, 10, 8);
        measure("wrap_new", 0, 1, 10, 6);

        cmd(1, 7, 5);
        cmd(3, 7, 0);
        cmd(9, 0, 32'hFFFF_FFFF);
        cmd(1, 0, 2, 8'h05);
        cmd(4, 0, 0);
        measure("bad_cmds", 0, 2, 10, 6);

        for (int k = 0; k < 200; k++) begin
            op = $urandom_range(0, 9);
            ch = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            b = $urandom;
            if (op == 1 || op == 2) b = $urandom_range(0, 15);
            cmd(op, ch, b, ($urandom_range(0, 9) == 0) ? 8'h03 : 8'h00);
            gap = $urandom_range(0, 3);
            if (gap != 0) idle(gap);
        end

        cmd(2, 0, 10);
        cmd(1, 0, 8);
        cmd(0, 0, 1);
        cmd(5, 0, 0);
        measure("pre_rst", 0, 2, 10, 8);
        for (int k = 0; k < 20 && !m_pins[0]; k++) idle(1);
        reset = 1'b1;
        start = 1'b1;
        valueA = 32'd4;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        valueA = '0;
        @(negedge clock);
        check("rst_pins", 32'(pwmPins), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clock);
        #1;
        cmd(4, 0, 0);

        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            seen = periodTick;
        end
        check("rst_first_tick", 32'(seen), 32'd1);
        len = 0;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            len++;
            seen = periodTick;
        end
        check("rst_period", len, DEF);
        idle(5);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- Parametrised successor to the team's 2-channel servo PWM custom instruction.
- Drives NR_CHANNELS PWM outputs from one shared period counter.
- Per-channel duty, enable and polarity are programmable over the custom-instruction interface.
- Duty and period writes are double-buffered (glitch-free at period boundary); configuration is readable back.

Parameters:
- customId, 8'h00, custom-instruction number this block answers to
- NR_CHANNELS, 4, number of PWM outputs (1..16)
- CNT_WIDTH, 20, width of period counter and of duty/period registers (8..32)
- DEFAULT_PERIOD, 20'd1000000, period loaded at reset, in clock cycles

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  custom-instruction start strobe
- ciN  in  8  custom-instruction number
- valueA  in  32  command word: [3:0] opcode, [11:8] channel index
- valueB  in  32  operand
- done  out  1  one-cycle completion pulse
- result  out  32  read data, valid while done=1, else 0
- pwmPins  out  NR_CHANNELS  PWM outputs, registered
- periodTick  out  1  one-cycle pulse on the cycle the counter wraps to 0

Behaviour:
- Reset is synchronous, active-high, applied on the clock edge. On reset:
  - counter=0, period_active=period_shadow=DEFAULT_PERIOD
  - all duty_shadow/duty_active=0
  - enable=0, polarity=0
  - pwmPins=0, done=0, result=0, periodTick=0
- A command is accepted when start=1 and ciN==customId. Start while reset=1 is ignored.
- Latency: done=1 exactly one cycle after acceptance, for one cycle; result is registered alongside it.
- Back-to-back commands on consecutive cycles must all be accepted.
- Opcodes:
  - 0: enable mask <= valueB[NR_CHANNELS-1:0]; takes effect next cycle.
  - 1: duty_shadow[ch] <= valueB[CNT_WIDTH-1:0].
  - 2: period_shadow <= valueB[CNT_WIDTH-1:0].
  - 3: result <= zero-extended duty_active[ch].
  - 4: result <= {enable mask, zero-extended} in [15:0]; current counter in [31:16] (counter truncated to its 16 LSBs).
  - 5: polarity mask <= valueB[NR_CHANNELS-1:0]; takes effect next cycle.
  - Other opcodes: no state change, result=0, done still pulses.
- Channel index >= NR_CHANNELS: writes ignored, reads return 0, done still pulses.
- Counter:
  - Increments every cycle.
  - When counter == period_active-1, the next value is 0; periodTick=1 on the cycle counter==0 is registered.
  - On that wrap, duty_active <= duty_shadow for all channels and period_active <= period_shadow.
  - A shadow write in the same cycle as the wrap is NOT transferred; it applies at the following wrap.
- period_active==0 or 1: counter is held at 0 and shadows transfer every cycle.
- Output: raw[i] = enable[i] & (counter < duty_active[i]); pwmPins[i] <= raw[i] ^ polarity[i], registered one cycle.
  - duty 0 gives constant inactive level.
  - duty >= period gives constant active level (100%).
  - A disabled channel outputs polarity[i].
- Arithmetic: unsigned throughout; operands are truncated to CNT_WIDTH; no saturation.
- Reset mid-period forces the outputs above on the next edge; any in-flight done is cancelled.

Test Plan:
- Reset with period=10 (via op2, then wait one wrap), duty ch0=3 (op1), enable=4'b0001 (op0) -> pwmPins[0] is high 3 cycles, low 7, repeating; periodTick every 10 cycles.
- Mid-period, write duty ch0=8 -> current period keeps 3-cycle high; the first full period after the next wrap shows 8-cycle high; op3 reads 3 before the wrap and 8 after.
- Duty=0 and duty=12 on ch1 with period=10 -> constant 0, then constant 1; polarity bit1=1 inverts both; enable bit1=0 -> pin = polarity.
- Shadow write on the exact wrap cycle -> value appears only after the second wrap.
- Command with ch=7 (NR_CHANNELS=4), op1 -> no change, done pulses; op9 -> result=0, done pulses; wrong ciN -> no done.
- Assert reset for 1 cycle mid-period with outputs high -> next cycle pwmPins=0, done=0, counter=0, period restored to DEFAULT_PERIOD.
